// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the bus masters and the round-robin arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface bus_arbiter_if #(
    parameter int MASTER_NUM = 4,
    parameter int OWNER_W    = 2
);
    logic [MASTER_NUM-1:0] Req_;
    logic [MASTER_NUM-1:0] Grnt_;
    logic [OWNER_W-1:0]    Owner;
    logic                  BusIdle;
    logic                  Timeout;

    modport slave (
        input  Req_,
        output Grnt_,
        output Owner,
        output BusIdle,
        output Timeout
    );

    modport master (
        output Req_,
        input  Grnt_,
        input  Owner,
        input  BusIdle,
        input  Timeout
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with registered, active-low grants and zero-idle handover.
// Define BUS_ARB_TIMEOUT_EN to force a handover after MAX_HOLD contended cycles.
module bus_arbiter #(
    parameter int MASTER_NUM = 4,
    parameter int OWNER_W    = 2,
    parameter int MAX_HOLD   = 16
) (
    input  logic         clk,
    input  logic         reset,
    bus_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} arbState_e;

    localparam logic [OWNER_W-1:0] LAST_MASTER = OWNER_W'(MASTER_NUM - 1);

    arbState_e             state, stateNext;
    logic [OWNER_W-1:0]    ownerQ, ownerNext;
    logic [MASTER_NUM-1:0] grntQ, grntNext;
    logic                  busIdleQ;
    logic                  timeoutQ, timeoutNext;
    logic [MASTER_NUM-1:0] reqAct;
    logic [MASTER_NUM-1:0] othersReq;

    // First requester after 'last', wrapping; 'last' itself is checked at the very end.
    function automatic logic [OWNER_W-1:0] rrPick(input logic [MASTER_NUM-1:0] reqs,
                                                  input logic [OWNER_W-1:0]    last);
        logic [OWNER_W-1:0] pick;
        logic               found;
        int                 idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= MASTER_NUM; k++) begin
            idx = (int'(last) + k) % MASTER_NUM;
            if (!found && reqs[idx]) begin
                pick  = OWNER_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign reqAct    = ~bus.Req_;
    assign othersReq = reqAct & ~(MASTER_NUM'(1) << ownerQ);

`ifdef BUS_ARB_TIMEOUT_EN
    logic [7:0] holdQ, holdNext;
`else
    logic unusedMaxHold;
    assign unusedMaxHold = ^8'(MAX_HOLD - 1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ownerQ   <= LAST_MASTER;
            grntQ    <= '1;
            busIdleQ <= 1'b1;
            timeoutQ <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            holdQ    <= '0;
`endif
        end else begin
            state    <= stateNext;
            ownerQ   <= ownerNext;
            grntQ    <= grntNext;
            busIdleQ <= (stateNext == IDLE);
            timeoutQ <= timeoutNext;
`ifdef BUS_ARB_TIMEOUT_EN
            holdQ    <= holdNext;
`endif
        end
    end

    always_comb begin
        stateNext   = state;
        ownerNext   = ownerQ;
        timeoutNext = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        holdNext    = holdQ;
`endif
        case (state)
            IDLE: begin
`ifdef BUS_ARB_TIMEOUT_EN
                holdNext = '0;
`endif
                if (|reqAct) begin
                    stateNext = GRANT;
                    ownerNext = rrPick(reqAct, ownerQ);
                end
            end
            GRANT: begin
                if (reqAct[ownerQ]) begin
`ifdef BUS_ARB_TIMEOUT_EN
                    // Contended hold: preempt once the owner has had its MAX_HOLD cycles.
                    if (|othersReq) begin
                        if (holdQ == 8'(MAX_HOLD - 1)) begin
                            ownerNext   = rrPick(othersReq, ownerQ);
                            timeoutNext = 1'b1;
                            holdNext    = '0;
                        end else begin
                            holdNext = holdQ + 8'd1;
                        end
                    end
`endif
                end else if (|othersReq) begin
                    ownerNext = rrPick(othersReq, ownerQ);
`ifdef BUS_ARB_TIMEOUT_EN
                    holdNext  = '0;
`endif
                end else begin
                    stateNext = IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
                    holdNext  = '0;
`endif
                end
            end
            default: stateNext = IDLE;
        endcase
        grntNext = (stateNext == GRANT) ? ~(MASTER_NUM'(1) << ownerNext) : '1;
    end

    assign bus.Grnt_   = grntQ;
    assign bus.Owner   = ownerQ;
    assign bus.BusIdle = busIdleQ;
    assign bus.Timeout = timeoutQ;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized checks of bus_arbiter against a cycle-level reference model.
module tb_bus_arbiter;
    localparam int N  = 4;
    localparam int OW = 2;
    localparam int MH = 4;
`ifdef BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    bit   mGranted;
    int   mOwner;
    int   mHold;
    bit   mTimeout;

    always #5 clk = ~clk;

    bus_arbiter_if #(.MASTER_NUM(N), .OWNER_W(OW)) bus ();

    bus_arbiter #(.MASTER_NUM(N), .OWNER_W(OW), .MAX_HOLD(MH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    function automatic int winner(input int from, input logic [N-1:0] want);
        for (int k = 1; k <= N; k++) begin
            if (want[(from + k) % N]) return (from + k) % N;
        end
        return from;
    endfunction

    task automatic modelReset();
        mGranted = 1'b0;
        mOwner   = N - 1;
        mHold    = 0;
        mTimeout = 1'b0;
    endtask

    // Predicts the arbiter state after the next rising edge given the sampled requests.
    task automatic modelEdge(input logic [N-1:0] reqN);
        logic [N-1:0] want;
        logic [N-1:0] others;
        want           = ~reqN;
        others         = want;
        others[mOwner] = 1'b0;
        mTimeout       = 1'b0;
        if (!mGranted) begin
            mHold = 0;
            if (|want) begin
                mGranted = 1'b1;
                mOwner   = winner(mOwner, want);
            end
        end else if (want[mOwner]) begin
            if (|others) begin
                if (TO_EN && mHold == MH - 1) begin
                    mOwner   = winner(mOwner, others);
                    mHold    = 0;
                    mTimeout = 1'b1;
                end else begin
                    mHold++;
                end
            end
        end else if (|others) begin
            mOwner = winner(mOwner, others);
            mHold  = 0;
        end else begin
            mGranted = 1'b0;
            mHold    = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkModel(input string tag);
        logic [N-1:0] expG;
        expG = mGranted ? ~(N'(1) << mOwner) : '1;
        chk({tag, ".grnt"},    32'(bus.Grnt_),   32'(expG));
        chk({tag, ".owner"},   32'(bus.Owner),   32'(mOwner));
        chk({tag, ".idle"},    32'(bus.BusIdle), 32'(!mGranted));
        chk({tag, ".timeout"}, 32'(bus.Timeout), 32'(mTimeout));
    endtask

    task automatic step(input logic [N-1:0] r);
        bus.Req_ = r;
        modelEdge(r);
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        logic [N-1:0] r;
        reset    = 1'b1;
        bus.Req_ = '1;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.grnt",    32'(bus.Grnt_),   32'h0000_000F);
        chk("rst.owner",   32'(bus.Owner),   32'd3);
        chk("rst.idle",    32'(bus.BusIdle), 32'd1);
        chk("rst.timeout", 32'(bus.Timeout), 32'd0);

        bus.Req_ = 4'b1110;
        repeat (2) @(posedge clk);
        #1;
        chk("rstHeld.grnt", 32'(bus.Grnt_), 32'h0000_000F);
        reset = 1'b0;

        step(4'b1101);
        chk("single.grnt",  32'(bus.Grnt_),   32'h0000_000D);
        chk("single.owner", 32'(bus.Owner),   32'd1);
        chk("single.idle",  32'(bus.BusIdle), 32'd0);
        checkModel("single");
        step(4'b1111);
        checkModel("singleRel");

        // All four request at once from a fresh reset; each releases for one cycle in turn.
        pulseReset();
        step(4'b0000);
        chk("rr0.owner", 32'(bus.Owner), 32'd0);
        chk("rr0.idle",  32'(bus.BusIdle), 32'd0);
        step(4'b0001);
        chk("rr1.owner", 32'(bus.Owner), 32'd1);
        chk("rr1.idle",  32'(bus.BusIdle), 32'd0);
        step(4'b0010);
        chk("rr2.owner", 32'(bus.Owner), 32'd2);
        chk("rr2.idle",  32'(bus.BusIdle), 32'd0);
        step(4'b0100);
        chk("rr3.owner", 32'(bus.Owner), 32'd3);
        chk("rr3.grnt",  32'(bus.Grnt_), 32'h0000_0007);
        checkModel("rr3");

        step(4'b1011);
        chk("toTwo.owner", 32'(bus.Owner), 32'd2);
        step(4'b1111);
        chk("noContender.grnt",  32'(bus.Grnt_),   32'h0000_000F);
        chk("noContender.idle",  32'(bus.BusIdle), 32'd1);
        chk("noContender.owner", 32'(bus.Owner),   32'd2);

        // Reset arriving between edges must drop the grant without waiting for a clock.
        step(4'b1101);
        chk("preAsync.owner", 32'(bus.Owner), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("async.grnt",  32'(bus.Grnt_),   32'h0000_000F);
        chk("async.idle",  32'(bus.BusIdle), 32'd1);
        chk("async.owner", 32'(bus.Owner),   32'd3);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        bus.Req_ = '1;
        modelReset();

        step(4'b0110);
        chk("hold.first", 32'(bus.Grnt_), 32'h0000_000E);
`ifdef BUS_ARB_TIMEOUT_EN
        for (int i = 0; i < MH - 1; i++) begin
            step(4'b0110);
            chk("hold.keep",    32'(bus.Grnt_),   32'h0000_000E);
            chk("hold.noPulse", 32'(bus.Timeout), 32'd0);
        end
        step(4'b0110);
        chk("timeout.grnt",  32'(bus.Grnt_),   32'h0000_0007);
        chk("timeout.owner", 32'(bus.Owner),   32'd3);
        chk("timeout.pulse", 32'(bus.Timeout), 32'd1);
        step(4'b0110);
        chk("timeout.oneCycle", 32'(bus.Timeout), 32'd0);
        checkModel("afterTimeout");
`else
        for (int i = 0; i < 100; i++) begin
            step(4'b0110);
            chk("hold.keep", 32'(bus.Grnt_),   32'h0000_000E);
            chk("hold.zero", 32'(bus.Timeout), 32'd0);
        end
`endif

        r = 4'b1111;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0) r = N'($urandom_range(0, (1 << N) - 1));
            step(r);
            checkModel("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
